// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for NUM_MASTERS masters with a grant-acceptance timeout.
// A granted master must raise bus_util before the timer saturates or it loses the grant.
module bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] b_request,
  input  logic                   bus_util,
  input  logic [NUM_MASTERS-1:0] slave_busy,
  output logic [NUM_MASTERS-1:0] b_grant,
  output logic [1:0]             grant_id,
  output logic                   arb_busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [TIMEOUT_LEN-1:0] timer_q, timer_d;
  logic [1:0]             last_served_q, last_served_d;
  logic [NUM_MASTERS-1:0] b_grant_q, b_grant_d;
  logic [1:0]             grant_id_q, grant_id_d;
  logic                   arb_busy_q, arb_busy_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [2:0]             pick;
  logic                   granted_req;

  // Returns {found, index}; scanning from the farthest offset down lets the
  // closest requester after `last` overwrite the result.
  function automatic logic [2:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                         input logic [1:0]             last);
    logic [2:0] r;
    r = 3'b000;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (req[j] && (j == ((int'(last) + i) % NUM_MASTERS))) r = {1'b1, 2'(j)};
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    last_served_d = last_served_q;
    b_grant_d     = b_grant_q;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;
    pick          = rr_pick(b_request, last_served_q);
    granted_req   = |(b_request & b_grant_q);

    case (state_q)
      S_IDLE: begin
        b_grant_d = '0;
        if (pick[2] && !(|slave_busy)) begin
          state_d       = S_GRANT;
          b_grant_d     = NUM_MASTERS'(1) << pick[1:0];
          grant_id_d    = pick[1:0];
          last_served_d = pick[1:0];
          timer_d       = '0;
        end
      end
      S_GRANT: begin
        timer_d = timer_q + TIMEOUT_LEN'(1);
        // bus_util takes priority over a simultaneous request drop or timeout
        if (bus_util) begin
          state_d = S_BUSY;
        end else if (!granted_req) begin
          state_d   = S_RELEASE;
          b_grant_d = '0;
        end else if (timer_d == '1) begin
          state_d       = S_RELEASE;
          b_grant_d     = '0;
          timeout_err_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (!bus_util) begin
          state_d   = S_RELEASE;
          b_grant_d = '0;
        end
      end
      S_RELEASE: begin
        state_d   = S_IDLE;
        b_grant_d = '0;
      end
      default: begin
        state_d   = S_IDLE;
        b_grant_d = '0;
      end
    endcase

    arb_busy_d = (state_d == S_GRANT) || (state_d == S_BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      last_served_q <= 2'(NUM_MASTERS - 1);
      b_grant_q     <= '0;
      grant_id_q    <= 2'd0;
      arb_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      last_served_q <= last_served_d;
      b_grant_q     <= b_grant_d;
      grant_id_q    <= grant_id_d;
      arb_busy_q    <= arb_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign b_grant     = b_grant_q;
  assign grant_id    = grant_id_q;
  assign arb_busy    = arb_busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against an ownership-based reference model.
module tb_bus_arbiter;
  localparam int N = 3;
  localparam int T = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] b_request;
  logic         bus_util;
  logic [N-1:0] slave_busy;
  logic [N-1:0] b_grant;
  logic [1:0]   grant_id;
  logic         arb_busy;
  logic         timeout_err;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_LEN(T)) dut (
    .clk(clk), .rst(rst), .b_request(b_request), .bus_util(bus_util),
    .slave_busy(slave_busy), .b_grant(b_grant), .grant_id(grant_id),
    .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, whether they have started using it,
  // how long they have held an unused grant, and how many dead cycles remain.
  int m_owner, m_last, m_cool, m_age;
  bit m_used, m_err;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_cool = 0; m_age = 0; m_used = 0; m_err = 0;
  endtask

  task automatic model_step();
    m_err = 0;
    if (m_owner >= 0) begin
      if (!m_used) begin
        m_age++;
        if (bus_util) m_used = 1;
        else if (((b_request >> m_owner) & 3'b001) == 3'b000) begin
          m_owner = -1; m_cool = 1;
        end else if (m_age == (1 << T) - 1) begin
          m_owner = -1; m_cool = 1; m_err = 1;
        end
      end else if (!bus_util) begin
        m_owner = -1; m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (b_request != '0 && slave_busy == '0) begin
      for (int k = 1; k <= N; k++) begin
        int m;
        m = (m_last + k) % N;
        if (((b_request >> m) & 3'b001) != 3'b000) begin
          m_owner = m; m_last = m; m_used = 0; m_age = 0;
          break;
        end
      end
    end
  endtask

  task automatic check_model(input int cyc);
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    check($sformatf("rand_grant[%0d]", cyc), 32'(b_grant), 32'(eg));
    check($sformatf("rand_busy[%0d]", cyc), 32'(arb_busy), 32'(m_owner >= 0));
    check($sformatf("rand_err[%0d]", cyc), 32'(timeout_err), 32'(m_err));
    if (m_owner >= 0) check($sformatf("rand_id[%0d]", cyc), 32'(grant_id), 32'(m_owner));
  endtask

  task automatic do_reset();
    rst = 1'b1; b_request = '0; bus_util = 1'b0; slave_busy = '0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         util;
    logic [N-1:0] sb;
    logic [N-1:0] g;
    logic [1:0]   id;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [N-1:0] req, input logic util, input logic [N-1:0] sb,
                              input logic [N-1:0] g, input logic [1:0] id, input logic busy);
    vec_t v;
    v.req = req; v.util = util; v.sb = sb; v.g = g; v.id = id; v.busy = busy;
    return v;
  endfunction

  int order[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic grant with 5-cycle transaction
    vecs.push_back(mk(3'b001, 1'b0, 3'b000, 3'b001, 2'd0, 1'b1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(3'b001, 1'b1, 3'b000, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    // slave busy blocks, then releases
    vecs.push_back(mk(3'b010, 1'b0, 3'b001, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(3'b010, 1'b0, 3'b001, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(3'b010, 1'b0, 3'b000, 3'b010, 2'd1, 1'b1));
    vecs.push_back(mk(3'b010, 1'b1, 3'b000, 3'b010, 2'd1, 1'b1));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    // bus_util in IDLE is ignored
    vecs.push_back(mk(3'b000, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0));
    // master 2 withdraws during GRANT
    vecs.push_back(mk(3'b100, 1'b0, 3'b000, 3'b100, 2'd2, 1'b1));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    // drop and bus_util together: bus_util wins; no preemption in BUSY
    vecs.push_back(mk(3'b001, 1'b0, 3'b000, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(3'b000, 1'b1, 3'b000, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(3'b110, 1'b1, 3'b000, 3'b001, 2'd0, 1'b1));
    vecs.push_back(mk(3'b110, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(3'b110, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(3'b110, 1'b0, 3'b000, 3'b010, 2'd1, 1'b1));
    vecs.push_back(mk(3'b110, 1'b1, 3'b000, 3'b010, 2'd1, 1'b1));
    vecs.push_back(mk(3'b100, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0));

    // reset state
    rst = 1'b1; b_request = '0; bus_util = 1'b0; slave_busy = '0;
    #3;
    check("reset_grant", 32'(b_grant), 32'(0));
    check("reset_id", 32'(grant_id), 32'(0));
    check("reset_busy", 32'(arb_busy), 32'(0));
    check("reset_err", 32'(timeout_err), 32'(0));
    do_reset();

    foreach (vecs[i]) begin
      b_request = vecs[i].req; bus_util = vecs[i].util; slave_busy = vecs[i].sb;
      tick();
      check($sformatf("vec%0d_grant", i), 32'(b_grant), 32'(vecs[i].g));
      check($sformatf("vec%0d_busy", i), 32'(arb_busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_err", i), 32'(timeout_err), 32'(0));
      if (vecs[i].busy) check($sformatf("vec%0d_id", i), 32'(grant_id), 32'(vecs[i].id));
    end

    // round robin with all masters requesting, 3-cycle transactions
    do_reset();
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
    b_request = 3'b111; bus_util = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr%0d_grant", i), 32'(b_grant), 32'(1 << order[i]));
      check($sformatf("rr%0d_id", i), 32'(grant_id), 32'(order[i]));
      bus_util = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        check($sformatf("rr%0d_hold%0d", i, c), 32'(b_grant), 32'(1 << order[i]));
      end
      bus_util = 1'b0;
      tick();
      check($sformatf("rr%0d_release", i), 32'(b_grant), 32'(0));
      tick();
      check($sformatf("rr%0d_gap", i), 32'(b_grant), 32'(0));
    end

    // timeout on master 1, master 2 waiting
    do_reset();
    b_request = 3'b010; bus_util = 1'b0;
    tick();
    check("to_grant", 32'(b_grant), 32'(3'b010));
    b_request = 3'b110;
    for (int k = 1; k < 15; k++) begin
      tick();
      check($sformatf("to_hold%0d", k), 32'(b_grant), 32'(3'b010));
      check($sformatf("to_noerr%0d", k), 32'(timeout_err), 32'(0));
    end
    tick();
    check("to_drop", 32'(b_grant), 32'(0));
    check("to_err", 32'(timeout_err), 32'(1));
    tick();
    check("to_err_pulse", 32'(timeout_err), 32'(0));
    check("to_release", 32'(b_grant), 32'(0));
    tick();
    check("to_next", 32'(b_grant), 32'(3'b100));

    // asynchronous reset during BUSY
    do_reset();
    b_request = 3'b001; bus_util = 1'b0;
    tick();
    bus_util = 1'b1;
    tick();
    check("rb_busy", 32'(arb_busy), 32'(1));
    check("rb_grant", 32'(b_grant), 32'(3'b001));
    #2 rst = 1'b1;
    #1;
    check("rb_async_grant", 32'(b_grant), 32'(0));
    check("rb_async_busy", 32'(arb_busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    b_request = 3'b111; bus_util = 1'b0;
    tick();
    check("rb_after_grant", 32'(b_grant), 32'(3'b001));

    // randomized traffic against the reference model
    do_reset();
    begin
      bit hold_mode;
      hold_mode = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 40 == 0) hold_mode = ($urandom_range(0, 2) == 0);
        if (hold_mode) begin
          b_request = 3'b111;
          bus_util  = ($urandom_range(0, 19) == 0);
        end else begin
          b_request = 3'($urandom);
          bus_util  = ($urandom_range(0, 9) < 6);
        end
        slave_busy = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        model_step();
        tick();
        check_model(cyc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
